// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini SRC control sequencer: IR field positions,
// opcode values, T-state encoding, instruction-class and control-word layouts.
package cpu_pkg;

    // Instruction register layout
    localparam int unsigned IR_W   = 32;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_MSB = 26;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_MSB = 22;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_MSB = 18;
    localparam int unsigned RC_LSB = 15;
    localparam int unsigned C2_MSB = 20;
    localparam int unsigned C2_LSB = 19;

    // Opcodes
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

    // Sequencer T-states
    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    // Instruction class, exactly one bit set for any opcode
    typedef struct packed {
        logic alu_rr;
        logic alu_imm;
        logic unary;
        logic muldiv;
        logic ld;
        logic ldi;
        logic st;
        logic br;
        logic jr;
        logic jal;
        logic inp;
        logic outp;
        logic mfhi;
        logic mflo;
        logic nop;
        logic halt;
    } iclass_t;

    // Datapath control word
    typedef struct packed {
        logic            pci;
        logic            pco;
        logic            inc_pc;
        logic            iri;
        logic            mari;
        logic            mdri;
        logic            mdro;
        logic            mem_read;
        logic            mem_write;
        logic            ryi;
        logic            rzi;
        logic            rzlo;
        logic            rzho;
        logic            hii;
        logic            hio;
        logic            loi;
        logic            loo;
        logic            gra;
        logic            grb;
        logic            grc;
        logic            rin;
        logic            rout;
        logic            baout;
        logic            csigno;
        logic            con_in;
        logic            ipo;
        logic            opi;
        logic [OP_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode-to-instruction-class decoder.
// Ports: opcode_i - IR opcode field; cls_c_o - one-hot instruction class.
module opcode_decoder
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] opcode_i,
    output iclass_t         cls_c_o
);

    // Unused opcodes fall into the nop class
    always_comb begin
        cls_c_o = '0;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:   cls_c_o.alu_rr  = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:        cls_c_o.alu_imm = 1'b1;
            OP_NEG, OP_NOT:                  cls_c_o.unary   = 1'b1;
            OP_MUL, OP_DIV:                  cls_c_o.muldiv  = 1'b1;
            OP_LD:                           cls_c_o.ld      = 1'b1;
            OP_LDI:                          cls_c_o.ldi     = 1'b1;
            OP_ST:                           cls_c_o.st      = 1'b1;
            OP_BR:                           cls_c_o.br      = 1'b1;
            OP_JR:                           cls_c_o.jr      = 1'b1;
            OP_JAL:                          cls_c_o.jal     = 1'b1;
            OP_IN:                           cls_c_o.inp     = 1'b1;
            OP_OUT:                          cls_c_o.outp    = 1'b1;
            OP_MFHI:                         cls_c_o.mfhi    = 1'b1;
            OP_MFLO:                         cls_c_o.mflo    = 1'b1;
            OP_HALT:                         cls_c_o.halt    = 1'b1;
            default:                         cls_c_o.nop     = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired T-state control sequencer for the Mini SRC datapath.
// Ports: clock/clear (async active-low); ir - instruction register; con_ff -
// branch condition; stop - halt at next fetch boundary; one registered strobe
// per datapath control input; alu_op - ALU operation; run - 0 in HALT.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned OPW = 5
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     ir,
    input  logic            con_ff,
    input  logic            stop,
    output logic            pci,
    output logic            pco,
    output logic            inc_pc,
    output logic            iri,
    output logic            mari,
    output logic            mdri,
    output logic            mdro,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ryi,
    output logic            rzi,
    output logic            rzlo,
    output logic            rzho,
    output logic            hii,
    output logic            hio,
    output logic            loi,
    output logic            loo,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            rin,
    output logic            rout,
    output logic            baout,
    output logic            csigno,
    output logic            con_in,
    output logic            ipo,
    output logic            opi,
    output logic [OPW-1:0]  alu_op,
    output logic            run
);

    state_t          state_q, state_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            run_q, run_d;
    logic            live_q;
    logic [OP_W-1:0] opcode;
    iclass_t         cls;
    logic            unused_ir_fields;

    assign opcode           = ir[OP_MSB:OP_LSB];
    assign unused_ir_fields = ^ir[OP_LSB-1:0];

    opcode_decoder u_dec (
        .opcode_i (opcode),
        .cls_c_o  (cls)
    );

    // State, control word and run flag; live_q holds the FSM in T0 for the
    // first edge after clear so the T0 strobes are presented for a full cycle.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_T0;
            ctrl_q  <= '0;
            run_q   <= 1'b1;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            run_q   <= run_d;
            live_q  <= 1'b1;
        end
    end

    // Next state, then the control word for that state (outputs are registered
    // so they line up with the state they belong to).
    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;
        run_d   = 1'b1;

        case (state_q)
            S_T0: state_d = stop ? S_HALT : S_T1;
            S_T1: state_d = S_T2;
            S_T2: begin
                if (cls.halt)     state_d = S_HALT;
                else if (cls.nop) state_d = S_T0;
                else              state_d = S_T3;
            end
            S_T3: begin
                if (cls.jr || cls.inp || cls.outp || cls.mfhi || cls.mflo)
                    state_d = S_T0;
                else
                    state_d = S_T4;
            end
            S_T4: state_d = (cls.unary || cls.jal) ? S_T0 : S_T5;
            S_T5: state_d = (cls.alu_rr || cls.alu_imm || cls.ldi) ? S_T0 : S_T6;
            S_T6: state_d = (cls.muldiv || cls.br) ? S_T0 : S_T7;
            S_T7: state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_T0;
        endcase

        if (!live_q) state_d = S_T0;

        run_d = (state_d != S_HALT);

        case (state_d)
            S_T0: begin
                ctrl_d.pco    = 1'b1;
                ctrl_d.mari   = 1'b1;
                ctrl_d.inc_pc = 1'b1;
                ctrl_d.rzi    = 1'b1;
            end
            S_T1: begin
                ctrl_d.rzlo     = 1'b1;
                ctrl_d.pci      = 1'b1;
                ctrl_d.mem_read = 1'b1;
                ctrl_d.mdri     = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdro = 1'b1;
                ctrl_d.iri  = 1'b1;
            end
            S_T3: begin
                if (cls.alu_rr || cls.alu_imm) begin
                    ctrl_d.grb  = 1'b1;
                    ctrl_d.rout = 1'b1;
                    ctrl_d.ryi  = 1'b1;
                end
                if (cls.unary) begin
                    ctrl_d.grb    = 1'b1;
                    ctrl_d.rout   = 1'b1;
                    ctrl_d.alu_op = opcode;
                    ctrl_d.rzi    = 1'b1;
                end
                if (cls.muldiv) begin
                    ctrl_d.gra  = 1'b1;
                    ctrl_d.rout = 1'b1;
                    ctrl_d.ryi  = 1'b1;
                end
                if (cls.ld || cls.ldi || cls.st) begin
                    ctrl_d.grb   = 1'b1;
                    ctrl_d.baout = 1'b1;
                    ctrl_d.ryi   = 1'b1;
                end
                if (cls.br) begin
                    ctrl_d.gra    = 1'b1;
                    ctrl_d.rout   = 1'b1;
                    ctrl_d.con_in = 1'b1;
                end
                if (cls.jr) begin
                    ctrl_d.gra  = 1'b1;
                    ctrl_d.rout = 1'b1;
                    ctrl_d.pci  = 1'b1;
                end
                // jal saves the return address into r15, selected through rb
                if (cls.jal) begin
                    ctrl_d.pco = 1'b1;
                    ctrl_d.rin = 1'b1;
                    ctrl_d.grb = 1'b1;
                end
                if (cls.inp) begin
                    ctrl_d.ipo = 1'b1;
                    ctrl_d.gra = 1'b1;
                    ctrl_d.rin = 1'b1;
                end
                if (cls.outp) begin
                    ctrl_d.gra  = 1'b1;
                    ctrl_d.rout = 1'b1;
                    ctrl_d.opi  = 1'b1;
                end
                if (cls.mfhi || cls.mflo) begin
                    ctrl_d.hio = cls.mfhi;
                    ctrl_d.loo = cls.mflo;
                    ctrl_d.gra = 1'b1;
                    ctrl_d.rin = 1'b1;
                end
            end
            S_T4: begin
                if (cls.alu_rr) begin
                    ctrl_d.grc    = 1'b1;
                    ctrl_d.rout   = 1'b1;
                    ctrl_d.alu_op = opcode;
                    ctrl_d.rzi    = 1'b1;
                end
                if (cls.alu_imm) begin
                    ctrl_d.csigno = 1'b1;
                    ctrl_d.alu_op = opcode;
                    ctrl_d.rzi    = 1'b1;
                end
                if (cls.unary) begin
                    ctrl_d.rzlo = 1'b1;
                    ctrl_d.gra  = 1'b1;
                    ctrl_d.rin  = 1'b1;
                end
                if (cls.muldiv) begin
                    ctrl_d.grb    = 1'b1;
                    ctrl_d.rout   = 1'b1;
                    ctrl_d.alu_op = opcode;
                    ctrl_d.rzi    = 1'b1;
                end
                // Effective address = base + sign-extended constant
                if (cls.ld || cls.ldi || cls.st) begin
                    ctrl_d.csigno = 1'b1;
                    ctrl_d.alu_op = OP_ADD;
                    ctrl_d.rzi    = 1'b1;
                end
                if (cls.br) begin
                    ctrl_d.pco = 1'b1;
                    ctrl_d.ryi = 1'b1;
                end
                if (cls.jal) begin
                    ctrl_d.gra  = 1'b1;
                    ctrl_d.rout = 1'b1;
                    ctrl_d.pci  = 1'b1;
                end
            end
            S_T5: begin
                if (cls.alu_rr || cls.alu_imm || cls.ldi) begin
                    ctrl_d.rzlo = 1'b1;
                    ctrl_d.gra  = 1'b1;
                    ctrl_d.rin  = 1'b1;
                end
                if (cls.muldiv) begin
                    ctrl_d.rzlo = 1'b1;
                    ctrl_d.loi  = 1'b1;
                end
                if (cls.ld || cls.st) begin
                    ctrl_d.rzlo = 1'b1;
                    ctrl_d.mari = 1'b1;
                end
                // Branch target = PC + sign-extended constant
                if (cls.br) begin
                    ctrl_d.csigno = 1'b1;
                    ctrl_d.alu_op = OP_ADD;
                    ctrl_d.rzi    = 1'b1;
                end
            end
            S_T6: begin
                if (cls.muldiv) begin
                    ctrl_d.rzho = 1'b1;
                    ctrl_d.hii  = 1'b1;
                end
                if (cls.ld) begin
                    ctrl_d.mem_read = 1'b1;
                    ctrl_d.mdri     = 1'b1;
                end
                if (cls.st) begin
                    ctrl_d.gra  = 1'b1;
                    ctrl_d.rout = 1'b1;
                    ctrl_d.mdri = 1'b1;
                end
                // CON was loaded in T3, so con_ff is settled by now
                if (cls.br) begin
                    ctrl_d.rzlo = 1'b1;
                    ctrl_d.pci  = con_ff;
                end
            end
            S_T7: begin
                if (cls.ld) begin
                    ctrl_d.mdro = 1'b1;
                    ctrl_d.gra  = 1'b1;
                    ctrl_d.rin  = 1'b1;
                end
                if (cls.st) begin
                    ctrl_d.mem_write = 1'b1;
                end
            end
            default: ctrl_d = '0;
        endcase
    end

    assign pci       = ctrl_q.pci;
    assign pco       = ctrl_q.pco;
    assign inc_pc    = ctrl_q.inc_pc;
    assign iri       = ctrl_q.iri;
    assign mari      = ctrl_q.mari;
    assign mdri      = ctrl_q.mdri;
    assign mdro      = ctrl_q.mdro;
    assign mem_read  = ctrl_q.mem_read;
    assign mem_write = ctrl_q.mem_write;
    assign ryi       = ctrl_q.ryi;
    assign rzi       = ctrl_q.rzi;
    assign rzlo      = ctrl_q.rzlo;
    assign rzho      = ctrl_q.rzho;
    assign hii       = ctrl_q.hii;
    assign hio       = ctrl_q.hio;
    assign loi       = ctrl_q.loi;
    assign loo       = ctrl_q.loo;
    assign gra       = ctrl_q.gra;
    assign grb       = ctrl_q.grb;
    assign grc       = ctrl_q.grc;
    assign rin       = ctrl_q.rin;
    assign rout      = ctrl_q.rout;
    assign baout     = ctrl_q.baout;
    assign csigno    = ctrl_q.csigno;
    assign con_in    = ctrl_q.con_in;
    assign ipo       = ctrl_q.ipo;
    assign opi       = ctrl_q.opi;
    assign alu_op    = OPW'(ctrl_q.alu_op);
    assign run       = run_q;

endmodule
